// File: rtl/flash_spi_pkg.sv
// ============================================================================
// Module      : flash_spi_pkg
// Description : Opcodes, FSM state encoding and status bit helpers shared by
//               the SPI-flash responder and its shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package flash_spi_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_RDID = 8'h9F;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_ADDR    = 4'd2,
        ST_DATA_RD = 4'd3,
        ST_DATA_PP = 4'd4,
        ST_STAT    = 4'd5,
        ST_ID      = 4'd6,
        ST_IGNORE  = 4'd7,
        ST_ERASE   = 4'd8,
        ST_PP_WAIT = 4'd9
    } state_t;

    localparam int STAT_WIP = 0;
    localparam int STAT_WEL = 1;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s           = 8'h00;
        s[STAT_WEL] = wel;
        s[STAT_WIP] = wip;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flash_spi_responder_shifter.sv
// ============================================================================
// Module      : spi_slave_shifter
// Description : Synchronises the SPI pins into i_clk, frames MOSI bytes and
//               shifts response bytes out on MISO (mode 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_shifter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_clk,
    input  logic       i_spi_cs,
    input  logic       i_spi_mosi,
    input  logic       i_tx_load,
    input  logic [7:0] i_tx_byte,
    output logic       o_spi_miso,
    output logic       o_cs_fall,
    output logic       o_cs_rise,
    output logic       o_byte_valid,
    output logic [7:0] o_rx_byte,
    output logic [5:0] o_bit_cnt
);

    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_mosi_sync;
    logic [2:0] r_bit_idx;
    logic [5:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_tx;
    logic       r_miso;
    logic       r_cs_fall;
    logic       r_cs_rise;
    logic       r_byte_valid;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_low;
    logic w_cs_fall_det;
    logic w_cs_rise_det;

    assign w_sclk_rise   = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_low      = ~r_cs_sync[1];
    assign w_cs_fall_det = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise_det = r_cs_sync[1] & ~r_cs_sync[2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync  <= 3'b000;
            r_cs_sync    <= 3'b111;
            r_mosi_sync  <= 2'b00;
            r_bit_idx    <= 3'd0;
            r_bit_cnt    <= 6'd0;
            r_rx         <= 8'h00;
            r_tx         <= 8'h00;
            r_miso       <= 1'b0;
            r_cs_fall    <= 1'b0;
            r_cs_rise    <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[1:0], i_spi_clk};
            r_cs_sync    <= {r_cs_sync[1:0], i_spi_cs};
            r_mosi_sync  <= {r_mosi_sync[0], i_spi_mosi};
            r_cs_fall    <= w_cs_fall_det;
            r_cs_rise    <= w_cs_rise_det;
            r_byte_valid <= 1'b0;

            if (w_cs_fall_det) begin
                r_bit_idx <= 3'd0;
                r_bit_cnt <= 6'd0;
            end else if (w_cs_low && w_sclk_rise) begin
                r_rx         <= {r_rx[6:0], r_mosi_sync[1]};
                r_bit_idx    <= r_bit_idx + 1'b1;
                r_byte_valid <= (r_bit_idx == 3'd7);
                // Total count saturates so an over-long SE never aliases to 32.
                if (r_bit_cnt != 6'd63) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            if (!w_cs_low || w_cs_fall_det) begin
                r_tx   <= 8'h00;
                r_miso <= 1'b0;
            end else if (i_tx_load) begin
                r_tx <= i_tx_byte;
            end else if (w_sclk_fall) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign o_spi_miso   = r_miso;
    assign o_cs_fall    = r_cs_fall;
    assign o_cs_rise    = r_cs_rise;
    assign o_byte_valid = r_byte_valid;
    assign o_rx_byte    = r_rx;
    assign o_bit_cnt    = r_bit_cnt;

endmodule

`default_nettype wire

// File: rtl/flash_spi_responder.sv
// ============================================================================
// Module      : flash_spi_responder
// Description : SPI-flash command responder (mode 0) in front of a byte-wide
//               memory port: status, ID, read, page program, sector erase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_spi_responder
    import flash_spi_pkg::*;
#(
    parameter int          P_ADDR_W       = 24,
    parameter int          P_PAGE_BYTES   = 256,
    parameter int          P_SECTOR_BYTES = 4096,
    parameter int          P_PP_BUSY      = 64,
    parameter logic [23:0] P_JEDEC_ID     = 24'hEF4017
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_spi_clk,
    input  logic                i_spi_cs,
    input  logic                i_spi_mosi,
    output logic                o_spi_miso,
    output logic [P_ADDR_W-1:0] o_mem_addr,
    output logic [7:0]          o_mem_wdata,
    output logic                o_mem_wen,
    output logic                o_mem_ren,
    input  logic [7:0]          i_mem_rdata,
    output logic [7:0]          o_status,
    output logic                o_busy
);

    localparam int c_SEC_W  = $clog2(P_SECTOR_BYTES);
    localparam int c_BUSY_W = $clog2(P_PP_BUSY + 1);
    localparam logic [P_ADDR_W-1:0] c_PAGE_MASK = P_ADDR_W'(P_PAGE_BYTES - 1);
    localparam logic [P_ADDR_W-1:0] c_SEC_MASK  = P_ADDR_W'(P_SECTOR_BYTES - 1);
    localparam logic [c_SEC_W-1:0]  c_SEC_LAST  = c_SEC_W'(P_SECTOR_BYTES - 1);

    logic       w_cs_fall;
    logic       w_cs_rise;
    logic       w_byte_valid;
    logic [7:0] w_rx_byte;
    logic [5:0] w_bit_cnt;
    logic       w_tx_load;
    logic [7:0] w_tx_byte;

    logic [23:0]         w_addr24;
    logic [P_ADDR_W-1:0] w_addr_full;
    logic [P_ADDR_W-1:0] w_pp_next;

    state_t              r_state;
    state_t              r_bg_state;
    logic [7:0]          r_op;
    logic [15:0]         r_addr_sh;
    logic [P_ADDR_W-1:0] r_addr;
    logic                r_wel;
    logic                r_wip;
    logic [1:0]          r_id_idx;
    logic                r_pp_wrote;
    logic [c_BUSY_W-1:0] r_busy_cnt;
    logic [c_SEC_W-1:0]  r_erase_cnt;
    logic [P_ADDR_W-1:0] r_erase_base;
    logic [P_ADDR_W-1:0] r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_mem_wen;
    logic                r_mem_ren;
    logic                r_rd_wait;
    logic                r_tx_load;
    logic [7:0]          r_tx_byte;
    logic [7:0]          r_status;

    spi_slave_shifter u_shifter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_spi_clk    (i_spi_clk),
        .i_spi_cs     (i_spi_cs),
        .i_spi_mosi   (i_spi_mosi),
        .i_tx_load    (w_tx_load),
        .i_tx_byte    (w_tx_byte),
        .o_spi_miso   (o_spi_miso),
        .o_cs_fall    (w_cs_fall),
        .o_cs_rise    (w_cs_rise),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte),
        .o_bit_cnt    (w_bit_cnt)
    );

    assign w_addr24    = {r_addr_sh, w_rx_byte};
    assign w_addr_full = w_addr24[P_ADDR_W-1:0];
    assign w_pp_next   = (r_addr & ~c_PAGE_MASK) | ((r_addr + 1'b1) & c_PAGE_MASK);

    // Read data bypasses a register so it reaches the shifter before the next SCLK fall.
    assign w_tx_load = r_tx_load | r_rd_wait;
    assign w_tx_byte = r_rd_wait ? i_mem_rdata : r_tx_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_bg_state   <= ST_IDLE;
            r_op         <= 8'h00;
            r_addr_sh    <= 16'h0000;
            r_addr       <= '0;
            r_wel        <= 1'b0;
            r_wip        <= 1'b0;
            r_id_idx     <= 2'd0;
            r_pp_wrote   <= 1'b0;
            r_busy_cnt   <= '0;
            r_erase_cnt  <= '0;
            r_erase_base <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_mem_wen    <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_rd_wait    <= 1'b0;
            r_tx_load    <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_status     <= 8'h00;
        end else begin
            r_mem_wen <= 1'b0;
            r_mem_ren <= 1'b0;
            r_tx_load <= 1'b0;
            r_rd_wait <= r_mem_ren;
            r_status  <= status_byte(r_wel, r_wip);

            if (w_cs_fall) begin
                r_state    <= ST_CMD;
                r_pp_wrote <= 1'b0;
            end else if (w_cs_rise) begin
                r_state <= ST_IDLE;
                if (r_state == ST_DATA_PP && r_pp_wrote) begin
                    r_bg_state <= ST_PP_WAIT;
                    r_wip      <= 1'b1;
                    r_busy_cnt <= c_BUSY_W'(P_PP_BUSY);
                end
                if (r_state == ST_ADDR && r_op == OP_SE && w_bit_cnt == 6'd32) begin
                    r_bg_state   <= ST_ERASE;
                    r_wip        <= 1'b1;
                    r_erase_base <= r_addr & ~c_SEC_MASK;
                    r_erase_cnt  <= '0;
                end
            end else if (w_byte_valid) begin
                case (r_state)
                    ST_CMD: begin
                        r_op    <= w_rx_byte;
                        r_state <= ST_IGNORE;
                        if (!r_wip || w_rx_byte == OP_RDSR) begin
                            case (w_rx_byte)
                                OP_WREN: r_wel <= 1'b1;
                                OP_WRDI: r_wel <= 1'b0;
                                OP_RDSR: begin
                                    r_state   <= ST_STAT;
                                    r_tx_load <= 1'b1;
                                    r_tx_byte <= status_byte(r_wel, r_wip);
                                end
                                OP_RDID: begin
                                    r_state   <= ST_ID;
                                    r_tx_load <= 1'b1;
                                    r_tx_byte <= P_JEDEC_ID[23:16];
                                    r_id_idx  <= 2'd1;
                                end
                                OP_READ: r_state <= ST_ADDR;
                                OP_PP, OP_SE: begin
                                    if (r_wel) begin
                                        r_state <= ST_ADDR;
                                    end
                                end
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        r_addr_sh <= {r_addr_sh[7:0], w_rx_byte};
                        if (w_bit_cnt == 6'd32) begin
                            r_addr <= w_addr_full;
                            if (r_op == OP_READ) begin
                                r_state    <= ST_DATA_RD;
                                r_mem_ren  <= 1'b1;
                                r_mem_addr <= w_addr_full;
                            end else if (r_op == OP_PP) begin
                                r_state <= ST_DATA_PP;
                            end
                        end
                    end
                    ST_DATA_RD: begin
                        r_addr     <= r_addr + 1'b1;
                        r_mem_ren  <= 1'b1;
                        r_mem_addr <= r_addr + 1'b1;
                    end
                    ST_DATA_PP: begin
                        r_mem_wen   <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_rx_byte;
                        r_addr      <= w_pp_next;
                        r_pp_wrote  <= 1'b1;
                    end
                    ST_STAT: begin
                        r_tx_load <= 1'b1;
                        r_tx_byte <= status_byte(r_wel, r_wip);
                    end
                    ST_ID: begin
                        r_tx_load <= 1'b1;
                        case (r_id_idx)
                            2'd1:    r_tx_byte <= P_JEDEC_ID[15:8];
                            2'd2:    r_tx_byte <= P_JEDEC_ID[7:0];
                            default: r_tx_byte <= 8'h00;
                        endcase
                        if (r_id_idx != 2'd3) begin
                            r_id_idx <= r_id_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Busy work runs beside the SPI FSM so RDSR stays serviceable.
            case (r_bg_state)
                ST_PP_WAIT: begin
                    if (r_busy_cnt == c_BUSY_W'(1)) begin
                        r_bg_state <= ST_IDLE;
                        r_wip      <= 1'b0;
                        r_wel      <= 1'b0;
                    end else begin
                        r_busy_cnt <= r_busy_cnt - 1'b1;
                    end
                end
                ST_ERASE: begin
                    r_mem_wen   <= 1'b1;
                    r_mem_addr  <= r_erase_base | P_ADDR_W'(r_erase_cnt);
                    r_mem_wdata <= 8'hFF;
                    r_erase_cnt <= r_erase_cnt + 1'b1;
                    if (r_erase_cnt == c_SEC_LAST) begin
                        r_bg_state <= ST_IDLE;
                        r_wip      <= 1'b0;
                        r_wel      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_ren   = r_mem_ren;
    assign o_status    = r_status;
    assign o_busy      = r_wip;

endmodule

`default_nettype wire

// File: tb/tb_flash_spi_responder.sv
// ============================================================================
// Module      : tb_flash_spi_responder
// Description : Directed self-checking bench for flash_spi_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_spi_responder;

    localparam int HALF       = 6;
    localparam int TB_PP_BUSY = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        miso;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  status;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ren_cnt = 0;
    int busy_cycles = 0;
    logic [31:0] wen_log[$];
    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;

    flash_spi_responder #(
        .P_ADDR_W       (24),
        .P_PAGE_BYTES   (256),
        .P_SECTOR_BYTES (4096),
        .P_PP_BUSY      (TB_PP_BUSY),
        .P_JEDEC_ID     (24'hEF4017)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_spi_clk   (spi_clk),
        .i_spi_cs    (spi_cs),
        .i_spi_mosi  (spi_mosi),
        .o_spi_miso  (miso),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wen   (mem_wen),
        .o_mem_ren   (mem_ren),
        .i_mem_rdata (mem_rdata),
        .o_status    (status),
        .o_busy      (busy)
    );

    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0100] <= 8'hA5;
            mem[16'h0101] <= 8'h5A;
            mem[16'h0102] <= 8'h3C;
        end
        if (mem_wen) begin
            mem[mem_addr[15:0]] <= mem_wdata;
            wen_log.push_back({mem_addr, mem_wdata});
        end
        if (mem_ren) begin
            mem_rdata <= mem[mem_addr[15:0]];
            ren_cnt   <= ren_cnt + 1;
        end
        if (busy) begin
            busy_cycles <= busy_cycles + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_cs = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(HALF);
            rx[i] = miso;
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        logic [7:0] rx;
        cs_low();
        spi_xfer(op, 8, rx);
        cs_high();
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, limit);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks += 6;
        if (miso !== 1'b0)      begin failures++; $display("FAIL reset_miso: got %b want 0", miso); end
        if (mem_wen !== 1'b0)   begin failures++; $display("FAIL reset_wen: got %b want 0", mem_wen); end
        if (mem_ren !== 1'b0)   begin failures++; $display("FAIL reset_ren: got %b want 0", mem_ren); end
        if (mem_addr !== 24'h0) begin failures++; $display("FAIL reset_addr: got %h want 000000", mem_addr); end
        if (mem_wdata !== 8'h0) begin failures++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
        if (status !== 8'h00)   begin failures++; $display("FAIL reset_status: got %h want 00", status); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_rdsr();
        logic [7:0] rx;
        cs_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL rdsr_reset: got %h want 00", rx); end
        one_byte_cmd(8'h06);
        checks++;
        if (status !== 8'h02) begin failures++; $display("FAIL status_wel: got %h want 02", status); end
        cs_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h02) begin failures++; $display("FAIL rdsr_wel: got %h want 02", rx); end
        spi_xfer(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h02) begin failures++; $display("FAIL rdsr_repeat: got %h want 02", rx); end
        cs_high();
    endtask

    task automatic test_rdid();
        logic [7:0] rx;
        logic [7:0] exp [0:3];
        exp[0] = 8'hEF; exp[1] = 8'h40; exp[2] = 8'h17; exp[3] = 8'h00;
        cs_low();
        spi_xfer(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) begin
            spi_xfer(8'h00, 8, rx);
            checks++;
            if (rx !== exp[i]) begin
                failures++;
                $display("FAIL rdid_byte%0d: got %h want %h", i, rx, exp[i]);
            end
        end
        cs_high();
    endtask

    task automatic test_read();
        logic [7:0] rx;
        int ren0;
        ren0 = ren_cnt;
        cs_low();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        checks++;
        if (rx !== 8'hA5) begin failures++; $display("FAIL read_b0: got %h want A5", rx); end
        spi_xfer(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h5A) begin failures++; $display("FAIL read_b1: got %h want 5A", rx); end
        checks++;
        if (ren_cnt - ren0 !== 3) begin failures++; $display("FAIL read_ren_count: got %0d want 3", ren_cnt - ren0); end
        spi_xfer(8'h00, 8, rx);
        checks++;
        if (rx !== 8'h3C) begin failures++; $display("FAIL read_b2: got %h want 3C", rx); end
        cs_high();
    endtask

    task automatic test_page_program();
        logic [7:0] rx;
        int n0;
        int b0;
        logic [31:0] exp [0:2];
        exp[0] = {24'h0000FE, 8'h11};
        exp[1] = {24'h0000FF, 8'h22};
        exp[2] = {24'h000000, 8'h33};
        one_byte_cmd(8'h04);
        checks++;
        if (status !== 8'h00) begin failures++; $display("FAIL wrdi_status: got %h want 00", status); end
        n0 = wen_log.size();
        cs_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'h77, 8, rx);
        cs_high();
        checks += 2;
        if (wen_log.size() !== n0) begin failures++; $display("FAIL pp_no_wel_wen: got %0d writes want 0", wen_log.size() - n0); end
        if (busy !== 1'b0) begin failures++; $display("FAIL pp_no_wel_busy: got %b want 0", busy); end

        one_byte_cmd(8'h06);
        n0 = wen_log.size();
        b0 = busy_cycles;
        cs_low();
        spi_xfer(8'h02, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'hFE, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        spi_xfer(8'h33, 8, rx);
        cs_high();
        checks++;
        if (wen_log.size() - n0 !== 3) begin
            failures++;
            $display("FAIL pp_wen_count: got %0d want 3", wen_log.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wen_log[n0 + i] !== exp[i]) begin
                    failures++;
                    $display("FAIL pp_write%0d: got %h want %h", i, wen_log[n0 + i], exp[i]);
                end
            end
        end
        cs_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        checks++;
        if (rx !== 8'h03) begin failures++; $display("FAIL pp_rdsr_busy: got %h want 03", rx); end
        wait_idle(2 * TB_PP_BUSY, "pp_busy_end");
        tick(2);
        checks++;
        if (busy_cycles - b0 !== TB_PP_BUSY) begin
            failures++;
            $display("FAIL pp_busy_len: got %0d want %0d", busy_cycles - b0, TB_PP_BUSY);
        end
        cs_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        checks++;
        if (rx !== 8'h00) begin failures++; $display("FAIL pp_rdsr_done: got %h want 00", rx); end
    endtask

    task automatic test_sector_erase();
        logic [7:0] rx;
        logic [31:0] exp;
        int n0;
        int ren0;
        int bad;
        one_byte_cmd(8'h06);
        n0 = wen_log.size();
        cs_low();
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h23, 8, rx);
        spi_xfer(8'h45, 8, rx);
        cs_high();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL se_busy: got %b want 1", busy); end

        ren0 = ren_cnt;
        cs_low();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        checks += 2;
        if (rx !== 8'h00) begin failures++; $display("FAIL read_in_erase_miso: got %h want 00", rx); end
        if (ren_cnt !== ren0) begin failures++; $display("FAIL read_in_erase_ren: got %0d want 0", ren_cnt - ren0); end

        cs_low();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        checks++;
        if (rx !== 8'h03) begin failures++; $display("FAIL rdsr_in_erase: got %h want 03", rx); end

        wait_idle(6000, "erase_end");
        tick(2);
        bad = 0;
        checks++;
        if (wen_log.size() - n0 !== 4096) begin
            failures++;
            $display("FAIL erase_wen_count: got %0d want 4096", wen_log.size() - n0);
        end else begin
            for (int k = 0; k < 4096; k++) begin
                exp = {24'h012000 + 24'(k), 8'hFF};
                if (wen_log[n0 + k] !== exp) bad++;
            end
            checks++;
            if (bad !== 0) begin failures++; $display("FAIL erase_writes: got %0d bad writes want 0", bad); end
        end
        checks++;
        if (status !== 8'h00) begin failures++; $display("FAIL erase_status: got %h want 00", status); end
    endtask

    task automatic test_short_commands();
        logic [7:0] rx;
        int n0;
        one_byte_cmd(8'h06);
        n0 = wen_log.size();
        cs_low();
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h23, 8, rx);
        spi_xfer(8'h45, 6, rx);
        cs_high();
        tick(20);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL se_short_busy: got %b want 0", busy); end
        if (wen_log.size() !== n0) begin failures++; $display("FAIL se_short_wen: got %0d writes want 0", wen_log.size() - n0); end

        one_byte_cmd(8'h04);
        cs_low();
        spi_xfer(8'h06, 5, rx);
        cs_high();
        checks++;
        if (status !== 8'h00) begin failures++; $display("FAIL partial_wren: got %h want 00", status); end
    endtask

    task automatic test_reset_mid_erase();
        logic [7:0] rx;
        one_byte_cmd(8'h06);
        cs_low();
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h01, 8, rx);
        spi_xfer(8'h20, 8, rx);
        spi_xfer(8'h00, 8, rx);
        cs_high();
        tick(50);
        checks++;
        if (mem_wen !== 1'b1) begin failures++; $display("FAIL mid_erase_wen: got %b want 1", mem_wen); end
        rst = 1'b1;
        tick(1);
        checks += 3;
        if (mem_wen !== 1'b0) begin failures++; $display("FAIL rst_erase_wen: got %b want 0", mem_wen); end
        if (status !== 8'h00) begin failures++; $display("FAIL rst_erase_status: got %h want 00", status); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL rst_erase_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_rdsr();
        test_rdid();
        test_read();
        test_page_program();
        test_sector_erase();
        test_short_commands();
        test_reset_mid_erase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
